vram_arbiter: RTL and testbench

- Shares the single-port, synchronous-read VRAM between three users: CPU stores decoded to the 0xD000_0000 window, the VGA text scanout reader, and a built-in screen-clear engine.
- CPU writes are buffered in a small FIFO so the single-cycle CPU rarely stalls.
- VGA reads get priority, bounded by a starvation limit.
- Sits between the bus decoder's VRAM outputs and the VRAM macro.

---
 rtl/vram_arb_pkg.sv | 17 +
 rtl/wr_fifo.sv | 50 +++++
 rtl/vram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter slice.
package vram_arb_pkg;

  // Default VRAM geometry: 1024 words of 32 bits.
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  // Top address nibble of the CPU window that the bus decoder maps onto VRAM.
  localparam logic [3:0] VRAM_BASE_NIBBLE = 4'hD;

  // Write-source selector: FIFO drain when idle, clear engine when clearing.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wr_fifo.sv
// Synchronous CPU write buffer; head entry is visible combinationally.
module wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[PW-1:0]];

  // Pointer update; a pop on an empty buffer is ignored so it can never underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[PW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA reads (starvation-bounded priority),
// buffered CPU stores and a full-screen clear engine.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int               ADDR_W       = ADDR_W_DEF,
  parameter int               DATA_W       = DATA_W_DEF,
  parameter int               FIFO_DEPTH   = 4,
  parameter int               STARVE_LIMIT = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  input  logic              vga_req_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic              vga_gnt_o,
  output logic              vga_valid_o,
  output logic [DATA_W-1:0] vga_rdata_o,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  output logic              ovf_o,
  input  logic              ovf_clr_i,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [DATA_W-1:0] vram_wdata_o,
  output logic              vram_we_o,
  input  logic [DATA_W-1:0] vram_rdata_i
);

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam int              FW         = ADDR_W + DATA_W;

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              ovf_q, ovf_d;
  logic              vga_valid_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FW-1:0]     fifo_head;
  logic              wr_pend, vga_win, wr_gnt;

  wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   ({cpu_addr_i, cpu_wdata_i}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Arbitration: VGA first unless starved-out writer, then pending write, else idle bus.
  always_comb begin
    wr_pend      = 1'b0;
    vga_win      = 1'b0;
    wr_gnt       = 1'b0;
    vram_we_o    = 1'b0;
    vram_addr_o  = {ADDR_W{1'b0}};
    vram_wdata_o = {DATA_W{1'b0}};
    if (state_q == ST_CLEAR) begin
      wr_pend = 1'b1;
    end else begin
      wr_pend = !fifo_empty;
    end
    // rst gates the grants so nothing reaches VRAM while reset is held.
    vga_win = !rst && vga_req_i && (starve_cnt_q < STARVE_MAX);
    wr_gnt  = !rst && !vga_win && wr_pend;
    if (vga_win) begin
      vram_addr_o = vga_addr_i;
    end else if (wr_gnt) begin
      vram_we_o = 1'b1;
      if (state_q == ST_CLEAR) begin
        vram_addr_o  = clr_ptr_q;
        vram_wdata_o = CLEAR_VALUE;
      end else begin
        vram_addr_o  = fifo_head[FW-1 -: ADDR_W];
        vram_wdata_o = fifo_head[DATA_W-1:0];
      end
    end else begin
      vram_we_o = 1'b0;
    end
  end

  assign fifo_push   = cpu_we_i && !fifo_full;
  assign fifo_pop    = wr_gnt && (state_q == ST_IDLE);
  assign cpu_stall_o = fifo_full;
  assign vga_gnt_o   = vga_win;
  assign vga_valid_o = vga_valid_q;
  assign vga_rdata_o = vga_valid_q ? vram_rdata_i : {DATA_W{1'b0}};
  assign clr_busy_o  = (state_q == ST_CLEAR);
  assign ovf_o       = ovf_q;

  // Next state: clear FSM, starvation counter and sticky overflow flag.
  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    ovf_d        = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start_i) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Last word of the screen ends the clear; the pointer is never wrapped.
        if (wr_gnt) begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == {ADDR_W{1'b1}}) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CLEAR;
          end
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_ptr_d = {ADDR_W{1'b0}};
      end
    endcase
    if (wr_pend && vga_win) begin
      if (starve_cnt_q == STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end else if (wr_gnt || !wr_pend) begin
      starve_cnt_d = {SW{1'b0}};
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
    // A drop wins over a simultaneous clear request.
    if (cpu_we_i && fifo_full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers; reset aborts a clear and cancels an in-flight read-valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_ptr_q    <= {ADDR_W{1'b0}};
      starve_cnt_q <= {SW{1'b0}};
      ovf_q        <= 1'b0;
      vga_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      ovf_q        <= ovf_d;
      vga_valid_q  <= vga_win;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: table of single-cycle vectors plus
// hand-written starvation, clear/overflow and mid-clear reset sequences.
module tb_vram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_we, cpu_stall, vga_req, vga_gnt, vga_valid;
  logic [AW-1:0] cpu_addr, vga_addr, vram_addr;
  logic [DW-1:0] cpu_wdata, vga_rdata, vram_wdata, vram_rdata;
  logic          clr_start, clr_busy, ovf, ovf_clr, vram_we;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_stall_o  (cpu_stall),
    .vga_req_i    (vga_req),
    .vga_addr_i   (vga_addr),
    .vga_gnt_o    (vga_gnt),
    .vga_valid_o  (vga_valid),
    .vga_rdata_o  (vga_rdata),
    .clr_start_i  (clr_start),
    .clr_busy_o   (clr_busy),
    .ovf_o        (ovf),
    .ovf_clr_i    (ovf_clr),
    .vram_addr_o  (vram_addr),
    .vram_wdata_o (vram_wdata),
    .vram_we_o    (vram_we),
    .vram_rdata_i (vram_rdata)
  );

  // VRAM model: read-first, one-cycle registered read.
  logic [DW-1:0] vmem [1024];
  always @(posedge clk) begin
    if (vram_we) vmem[vram_addr] <= vram_wdata;
    vram_rdata <= vmem[vram_addr];
  end

  typedef struct {
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          ovf_clr;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_gnt;
    logic          e_valid;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                              input logic vr, input logic [AW-1:0] va, input logic oc,
                              input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                              input logic eg, input logic ev, input logic [DW-1:0] er);
    vec_t v;
    v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
    v.vga_req = vr; v.vga_addr = va; v.ovf_clr = oc;
    v.e_we = ew; v.e_addr = ea; v.e_wdata = ed;
    v.e_gnt = eg; v.e_valid = ev; v.e_rdata = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    clr_start = 1'b0; ovf_clr = 1'b0;
  endtask

  initial begin
    // Table: one row per cycle, expectations for the cycle the inputs are applied.
    vecs[0]  = mk(1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 10'h010, 32'h12345678,  1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 1'b0, 32'h0);
    vecs[2]  = mk(1'b1, 10'h005, 32'hDEADBEEF,  1'b0, 10'h000, 1'b0, 1'b1, 10'h010, 32'h12345678,  1'b0, 1'b0, 32'h0);
    vecs[3]  = mk(1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF,  1'b0, 1'b0, 32'h0);
    vecs[4]  = mk(1'b0, 10'h000, 32'h0,         1'b1, 10'h010, 1'b0, 1'b0, 10'h010, 32'h0,         1'b1, 1'b0, 32'h0);
    vecs[5]  = mk(1'b0, 10'h000, 32'h0,         1'b1, 10'h005, 1'b0, 1'b0, 10'h005, 32'h0,         1'b1, 1'b1, 32'h12345678);
    vecs[6]  = mk(1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 1'b1, 32'hDEADBEEF);
    vecs[7]  = mk(1'b1, 10'h3FF, 32'hA5A50001,  1'b1, 10'h010, 1'b0, 1'b0, 10'h010, 32'h0,         1'b1, 1'b0, 32'h0);
    vecs[8]  = mk(1'b1, 10'h001, 32'h00000001,  1'b1, 10'h005, 1'b0, 1'b0, 10'h005, 32'h0,         1'b1, 1'b1, 32'h12345678);
    vecs[9]  = mk(1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b0, 1'b1, 10'h3FF, 32'hA5A50001,  1'b0, 1'b1, 32'hDEADBEEF);
    vecs[10] = mk(1'b0, 10'h000, 32'h0,         1'b1, 10'h3FF, 1'b0, 1'b0, 10'h3FF, 32'h0,         1'b1, 1'b0, 32'h0);
    vecs[11] = mk(1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b0, 1'b1, 10'h001, 32'h00000001,  1'b0, 1'b1, 32'hA5A50001);
    vecs[12] = mk(1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 1'b0, 32'h0);
    vecs[13] = mk(1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 32'h0,         1'b0, 1'b0, 32'h0);

    // Reset: outputs quiet even with a VGA request pending.
    drive_idle();
    vga_req = 1'b1;
    rst = 1'b1;
    #12;
    chk("reset_state", {vram_we, cpu_stall, vga_gnt, clr_busy, vga_valid, ovf}, 6'b0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      cpu_we = vecs[i].cpu_we; cpu_addr = vecs[i].cpu_addr; cpu_wdata = vecs[i].cpu_wdata;
      vga_req = vecs[i].vga_req; vga_addr = vecs[i].vga_addr; ovf_clr = vecs[i].ovf_clr;
      clr_start = 1'b0;
      #1;
      chk($sformatf("vec%0d", i),
          {vram_we, vram_addr, vram_wdata, vga_gnt, vga_valid, vga_rdata, cpu_stall, ovf, clr_busy},
          {vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_gnt, vecs[i].e_valid,
           vecs[i].e_rdata, 3'b000});
    end

    // Starvation: 8 VGA grants while a write waits, then the write, then VGA again.
    @(negedge clk);
    drive_idle();
    cpu_we = 1'b1; cpu_addr = 10'h100; cpu_wdata = 32'hCAFE0003;
    vga_req = 1'b1; vga_addr = 10'h040;
    #1;
    chk("starve_c0", {vga_gnt, vram_we}, 2'b10);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      cpu_we = 1'b0;
      #1;
      if (k == 9) begin
        chk("starve_write", {vga_gnt, vram_we, vram_addr, vram_wdata}, {1'b0, 1'b1, 10'h100, 32'hCAFE0003});
      end else begin
        chk($sformatf("starve_c%0d", k), {vga_gnt, vram_we}, 2'b10);
      end
    end

    // Clear: 1024 writes of zero, CPU stores fill the buffer and overflow meanwhile.
    @(negedge clk);
    drive_idle();
    clr_start = 1'b1;
    #1;
    chk("clr_start_cycle", {vram_we, clr_busy}, 2'b00);
    for (int c = 0; c < 1024; c++) begin
      @(negedge clk);
      drive_idle();
      clr_start = (c == 10);
      cpu_we    = (c < 5);
      cpu_addr  = 10'(32'h200 + c);
      cpu_wdata = 32'h100 + c;
      ovf_clr   = (c == 6);
      #1;
      chk("clear_seq", {vram_we, vram_addr, vram_wdata, clr_busy, vga_gnt},
          {1'b1, 10'(c), 32'h0, 1'b1, 1'b0});
      if (c == 3) chk("stall_before_full", {31'b0, cpu_stall}, 32'd0);
      if (c == 4) chk("stall_when_full", {31'b0, cpu_stall}, 32'd1);
      if (c == 5) chk("ovf_set", {31'b0, ovf}, 32'd1);
      if (c == 7) chk("ovf_cleared", {31'b0, ovf}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_idle();
      #1;
      chk($sformatf("drain%0d", k), {clr_busy, vram_we, vram_addr, vram_wdata},
          {1'b0, 1'b1, 10'(32'h200 + k), 32'h100 + k});
    end
    @(negedge clk);
    #1;
    chk("drain_done", {vram_we, cpu_stall, ovf}, 3'b000);

    // Reset in the middle of a clear with two stores queued and a read in flight.
    @(negedge clk);
    clr_start = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      drive_idle();
      cpu_we    = (c < 2);
      cpu_addr  = 10'(32'h300 + c);
      cpu_wdata = 32'h300 + c;
      vga_req   = (c == 100);
      vga_addr  = 10'h005;
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("pre_rst", {clr_busy, vga_valid, vram_we, vram_addr}, {1'b1, 1'b1, 1'b1, 10'd100});
    rst = 1'b1;
    vga_req = 1'b1;
    #1;
    chk("rst_mid", {clr_busy, vram_we, cpu_stall, vga_gnt, vga_valid, ovf}, 6'b0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d", k), {vram_we, clr_busy, cpu_stall}, 3'b000);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
